// File: rtl/adc_sipo_capture.sv
// Serial-in/parallel-out capture for the ADC frame: shifts sdata during transfer,
// validates the frame at close and queues good samples in a 2-entry FIFO.
module adc_sipo_capture #(
  parameter int DATA_W = 12,
  parameter int LEAD_Z = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic              sdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int F = LEAD_Z + DATA_W;
  localparam logic [1:0] ST_CNT_RST = 2'd1;
  localparam logic [1:0] ST_XFER    = 2'd2;
  localparam logic [1:0] ST_END     = 2'd3;

  logic [F-1:0]      sr_r;
  logic [4:0]        bitcnt_r;
  logic [1:0]        state_q_r;
  logic [DATA_W-1:0] e0_r, e1_r, e0_nxt_s, e1_nxt_s;
  logic [1:0]        cnt_r, cnt_nxt_s;
  logic              valid_r, frame_err_r, overrun_r, overrun_nxt_s;
  logic [CNT_W-1:0]  drop_cnt_r, err_cnt_r;
  logic              close_s, good_s, push_s, pop_s, bad_s;

  // Frame close is the first END cycle directly after a transfer cycle.
  assign close_s = (state == ST_END) && (state_q_r == ST_XFER);
  assign good_s  = (bitcnt_r == 5'(F)) && (sr_r[F-1:DATA_W] == {LEAD_Z{1'b0}});
  assign push_s  = close_s && good_s;
  assign bad_s   = close_s && !good_s;
  assign pop_s   = valid_r && sample_ready;

  // Serial shift register, bit counter and registered controller state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_r      <= {F{1'b0}};
      bitcnt_r  <= 5'd0;
      state_q_r <= 2'd0;
    end else begin
      state_q_r <= state;
      if (state == ST_XFER) begin
        sr_r <= {sr_r[F-2:0], sdata};
        if (bitcnt_r != 5'd31) begin
          bitcnt_r <= bitcnt_r + 5'd1;
        end
      end else if (state == ST_CNT_RST) begin
        bitcnt_r <= 5'd0;
      end
    end
  end

  // Two-entry buffer next state: e0 is always the head, so it drives sample directly.
  always_comb begin
    e0_nxt_s      = e0_r;
    e1_nxt_s      = e1_r;
    cnt_nxt_s     = cnt_r;
    overrun_nxt_s = 1'b0;
    case (cnt_r)
      2'd0: begin
        if (push_s) begin
          e0_nxt_s  = sr_r[DATA_W-1:0];
          cnt_nxt_s = 2'd1;
        end else begin
          cnt_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          e0_nxt_s = sr_r[DATA_W-1:0];
        end else if (push_s) begin
          e1_nxt_s  = sr_r[DATA_W-1:0];
          cnt_nxt_s = 2'd2;
        end else if (pop_s) begin
          cnt_nxt_s = 2'd0;
        end else begin
          cnt_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_nxt_s = e1_r;
          if (push_s) begin
            e1_nxt_s = sr_r[DATA_W-1:0];
          end else begin
            cnt_nxt_s = 2'd1;
          end
        end else if (push_s) begin
          overrun_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = 2'd2;
        end
      end
      default: begin
        cnt_nxt_s = 2'd0;
      end
    endcase
  end

  // Buffer storage, status pulses and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_r        <= {DATA_W{1'b0}};
      e1_r        <= {DATA_W{1'b0}};
      cnt_r       <= 2'd0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      drop_cnt_r  <= {CNT_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      e0_r        <= e0_nxt_s;
      e1_r        <= e1_nxt_s;
      cnt_r       <= cnt_nxt_s;
      valid_r     <= (cnt_nxt_s != 2'd0);
      frame_err_r <= bad_s;
      overrun_r   <= overrun_nxt_s;
      if (overrun_nxt_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
      if (bad_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
    end
  end

  assign sample       = e0_r;
  assign sample_valid = valid_r;
  assign frame_err    = frame_err_r;
  assign overrun      = overrun_r;
  assign drop_count   = drop_cnt_r;
  assign err_count    = err_cnt_r;

endmodule

// File: tb/tb_adc_sipo_capture.sv
// Directed self-checking bench for adc_sipo_capture: frame validation, buffering,
// backpressure, simultaneous push/pop and asynchronous reset.
module tb_adc_sipo_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic        sdata;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_err;
  logic        overrun;
  logic [15:0] drop_count;
  logic [15:0] err_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  adc_sipo_capture dut (
    .clk(clk), .reset(reset), .state(state), .sdata(sdata),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .frame_err(frame_err), .overrun(overrun),
    .drop_count(drop_count), .err_count(err_count)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count-reset cycle then n transfer cycles, MSB of the 15-bit frame first.
  task automatic send_bits(input logic [14:0] bits, input int n);
    state = 2'd1; tick();
    for (int i = 0; i < n; i++) begin
      state = 2'd2;
      sdata = bits[14-i];
      tick();
    end
  endtask

  task automatic close_frame();
    state = 2'd3; tick();
  endtask

  task automatic idle();
    state = 2'd0; sdata = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; state = 2'd0; sdata = 1'b0; sample_ready = 1'b0;
    #5;
    total_cnt++; if (sample !== 12'h000) $display("FAIL reset_sample: got %h expected 000", sample); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sample_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_pulses: got %b%b expected 00", frame_err, overrun); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd0 || err_count !== 16'd0) $display("FAIL reset_counts: got %0d/%0d expected 0/0", drop_count, err_count); else pass_cnt++;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    sample_ready = 1'b1;
    send_bits(15'b000_1010_0101_1010, 15);
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL nom_valid_early: got %b expected 0", sample_valid); else pass_cnt++;
    close_frame();
    total_cnt++; if (sample_valid !== 1'b1) $display("FAIL nom_valid: got %b expected 1", sample_valid); else pass_cnt++;
    total_cnt++; if (sample !== 12'hA5A) $display("FAIL nom_sample: got %h expected a5a", sample); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL nom_err: got %b expected 0", frame_err); else pass_cnt++;
    idle();
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL nom_pop: got %b expected 0", sample_valid); else pass_cnt++;
    sample_ready = 1'b0;
  endtask

  task automatic test_lead_zero();
    send_bits(15'b010_1111_1111_1111, 15);
    close_frame();
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL lz_err: got %b expected 1", frame_err); else pass_cnt++;
    total_cnt++; if (err_count !== 16'd1) $display("FAIL lz_count: got %0d expected 1", err_count); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL lz_valid: got %b expected 0", sample_valid); else pass_cnt++;
    close_frame();
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL lz_pulse_width: got %b expected 0", frame_err); else pass_cnt++;
    total_cnt++; if (err_count !== 16'd1) $display("FAIL lz_once: got %0d expected 1", err_count); else pass_cnt++;
    idle();
  endtask

  task automatic test_short_frame();
    send_bits(15'h0123, 14);
    close_frame();
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL short_err: got %b expected 1", frame_err); else pass_cnt++;
    total_cnt++; if (err_count !== 16'd2) $display("FAIL short_count: got %0d expected 2", err_count); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL short_nopush: got %b expected 0", sample_valid); else pass_cnt++;
    idle();
    send_bits(15'h0123, 15);
    close_frame();
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'h123) $display("FAIL short_next: got %b/%h expected 1/123", sample_valid, sample); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL short_next_err: got %b expected 0", frame_err); else pass_cnt++;
    idle();
    sample_ready = 1'b1; tick();
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL short_drain: got %b expected 0", sample_valid); else pass_cnt++;
    sample_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    send_bits(15'h0001, 15); close_frame(); idle();
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'h001) $display("FAIL bp_first: got %b/%h expected 1/001", sample_valid, sample); else pass_cnt++;
    send_bits(15'h0002, 15); close_frame(); idle();
    send_bits(15'h0003, 15); close_frame();
    total_cnt++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b expected 1", overrun); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd1) $display("FAIL bp_drop: got %0d expected 1", drop_count); else pass_cnt++;
    total_cnt++; if (sample !== 12'h001) $display("FAIL bp_head: got %h expected 001", sample); else pass_cnt++;
    idle();
    total_cnt++; if (overrun !== 1'b0) $display("FAIL bp_overrun_width: got %b expected 0", overrun); else pass_cnt++;
    sample_ready = 1'b1; tick();
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'h002) $display("FAIL bp_second: got %b/%h expected 1/002", sample_valid, sample); else pass_cnt++;
    tick();
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", sample_valid); else pass_cnt++;
    sample_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    send_bits(15'h0011, 15); close_frame(); idle();
    send_bits(15'h0022, 15); close_frame(); idle();
    send_bits(15'h07FF, 15);
    sample_ready = 1'b1;
    close_frame();
    total_cnt++; if (overrun !== 1'b0) $display("FAIL pp_overrun: got %b expected 0", overrun); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd1) $display("FAIL pp_drop: got %0d expected 1", drop_count); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'h022) $display("FAIL pp_second: got %b/%h expected 1/022", sample_valid, sample); else pass_cnt++;
    idle();
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'h7FF) $display("FAIL pp_third: got %b/%h expected 1/7ff", sample_valid, sample); else pass_cnt++;
    tick();
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL pp_empty: got %b expected 0", sample_valid); else pass_cnt++;
    sample_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_bits(15'h0055, 15); close_frame(); idle();
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'h055) $display("FAIL rm_buffered: got %b/%h expected 1/055", sample_valid, sample); else pass_cnt++;
    send_bits(15'h7FFF, 7);
    reset = 1'b1;
    #1;
    total_cnt++; if (sample_valid !== 1'b0 || sample !== 12'h000) $display("FAIL rm_async_out: got %b/%h expected 0/000", sample_valid, sample); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd0 || err_count !== 16'd0) $display("FAIL rm_async_cnt: got %0d/%0d expected 0/0", drop_count, err_count); else pass_cnt++;
    state = 2'd0; sdata = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    send_bits(15'h0FFF, 15);
    close_frame();
    total_cnt++; if (sample_valid !== 1'b1 || sample !== 12'hFFF) $display("FAIL rm_capture: got %b/%h expected 1/fff", sample_valid, sample); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0 || err_count !== 16'd0) $display("FAIL rm_err: got %b/%0d expected 0/0", frame_err, err_count); else pass_cnt++;
    idle();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lead_zero();
    test_short_frame();
    test_backpressure();
    test_push_pop_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
